adder_pipe_n: RTL



---
 rtl/adder_pkg.sv | 12 +
 rtl/adder_chunk.sv | 33 +++
 rtl/fullAdder.sv | 13 +
 rtl/adder_pipe_n.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared constants and helpers for the pipelined add/subtract unit.
// Chunk k of an operand occupies bits [chunk_lo(k,W) +: W].
package adder_pkg;

    localparam int unsigned N_DEF      = 32;
    localparam int unsigned STAGES_DEF = 4;

    function automatic int unsigned chunk_lo(input int unsigned k, input int unsigned w);
        return k * w;
    endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational W-bit ripple adder built from fullAdder cells.
// Cmsb_in exposes the carry into bit W-1 so the top chunk can derive signed overflow.
module adder_chunk
    import adder_pkg::*;
#(
    parameter int unsigned W = 8
) (
    output logic [W-1:0] S,
    output logic         Co,
    output logic         Cmsb_in,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         Ci
);

    logic [W:0] c;

    assign c[0] = Ci;

    for (genvar i = 0; i < W; i++) begin : g_bit
        fullAdder u_fa (
            .s  (S[i]),
            .co (c[i+1]),
            .a  (A[i]),
            .b  (B[i]),
            .ci (c[i])
        );
    end

    assign Co      = c[W];
    assign Cmsb_in = c[W-1];

endmodule

// File: rtl/fullAdder.sv
// Single-bit full adder cell.
module fullAdder (
    output logic s,
    output logic co,
    input  logic a,
    input  logic b,
    input  logic ci
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/adder_pipe_n.sv
// Pipelined N-bit add/subtract unit: one W-bit chunk per stage, carry registered between stages,
// valid/ready handshake with a global stall when the consumer holds off.
module adder_pipe_n
    import adder_pkg::*;
#(
    parameter int unsigned N      = N_DEF,
    parameter int unsigned STAGES = STAGES_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] Sum,
    output logic         Cout,
    output logic         Ovf
);

    localparam int unsigned W = N / STAGES;

    if (N % STAGES != 0) begin : g_bad_cfg
        $error("adder_pipe_n: N (%0d) must be a multiple of STAGES (%0d)", N, STAGES);
    end

    logic         stall;
    logic         adv;
    logic [N-1:0] bx;
    logic         c0;
    logic         ovf_q;

    assign stall    = out_valid & ~out_ready;
    assign adv      = ~stall;
    assign in_ready = ~stall;

    assign bx = sub ? ~B : B;
    assign c0 = sub ? 1'b1 : Cin;

    // Stage k holds result chunks 0..k plus the operand chunks k+1..STAGES-1 still to be added.
    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int unsigned LO = chunk_lo(k, W);

        logic             valid_q;
        logic [LO+W-1:0]  sum_q;
        logic             c_q;

        logic [W-1:0]     a_c;
        logic [W-1:0]     b_c;
        logic [W-1:0]     s_c;
        logic             ci_c;
        logic             co_c;
        logic             vin;
        logic [LO+W-1:0]  sum_d;

        if (k == 0) begin : g_src
            assign a_c   = A[chunk_lo(0, W) +: W];
            assign b_c   = bx[chunk_lo(0, W) +: W];
            assign ci_c  = c0;
            assign vin   = in_valid;
            assign sum_d = s_c;
        end else begin : g_src
            assign a_c   = g_stg[k-1].g_skew.a_q[W-1:0];
            assign b_c   = g_stg[k-1].g_skew.b_q[W-1:0];
            assign ci_c  = g_stg[k-1].c_q;
            assign vin   = g_stg[k-1].valid_q;
            assign sum_d = {s_c, g_stg[k-1].sum_q};
        end

        if (k < STAGES - 1) begin : g_skew
            localparam int unsigned SW = N - LO - W;

            logic [SW-1:0] a_q;
            logic [SW-1:0] b_q;
            logic [SW-1:0] a_d;
            logic [SW-1:0] b_d;

            if (k == 0) begin : g_next
                assign a_d = A[N-1:W];
                assign b_d = bx[N-1:W];
            end else begin : g_next
                assign a_d = g_stg[k-1].g_skew.a_q[N-LO-1:W];
                assign b_d = g_stg[k-1].g_skew.b_q[N-LO-1:W];
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end

        if (k == STAGES - 1) begin : g_top
            logic cm_c;

            adder_chunk #(.W(W)) u_chunk (
                .S       (s_c),
                .Co      (co_c),
                .Cmsb_in (cm_c),
                .A       (a_c),
                .B       (b_c),
                .Ci      (ci_c)
            );

            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (adv) begin
                    ovf_q <= cm_c ^ co_c;
                end
            end
        end else begin : g_mid
            logic cmsb_unused;

            adder_chunk #(.W(W)) u_chunk (
                .S       (s_c),
                .Co      (co_c),
                .Cmsb_in (cmsb_unused),
                .A       (a_c),
                .B       (b_c),
                .Ci      (ci_c)
            );
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                sum_q   <= '0;
                c_q     <= 1'b0;
            end else if (adv) begin
                valid_q <= vin;
                sum_q   <= sum_d;
                c_q     <= co_c;
            end
        end
    end

    assign out_valid = g_stg[STAGES-1].valid_q;
    assign Sum       = g_stg[STAGES-1].sum_q;
    assign Cout      = g_stg[STAGES-1].c_q;
    assign Ovf       = ovf_q;

endmodule
